sevenseg_scan_driver: RTL and testbench

- Downstream consumer of the stopwatch's BCD outputs digit3..digit0. Drives a 4-digit, common-anode, multiplexed 7-segment display.
- Displays the value as "d3 d2 . d1 d0", with the decimal point after digit2.
- Provides time-multiplexed anode scanning, BCD-to-segment decoding, a per-frame digit snapshot (no tearing), leading-zero blanking and a ghosting guard cycle.

---
 rtl/sevenseg_scan_driver.sv | 130 +++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver.
// Shows "d3 d2 . d1 d0": one digit is lit per slot, with a dark guard cycle
// between slots to suppress ghosting. All four digits are captured together at
// the start of each frame, so a value that changes mid-frame cannot tear.
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV   = 100000,  // clock cycles per digit slot, >= 2
  parameter int DP_POS        = 2,       // scan index whose decimal point is lit
  parameter bit BLANK_LEADING = 1'b1     // show a zero tens digit as blank
) (
  input  logic       clk_100MHz,
  input  logic       reset,        // asynchronous, active-low
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [1:0]    DP_IDX        = 2'(DP_POS);

  logic [PW-1:0] prescaler_reg;
  logic          tick;
  logic [1:0]    idx_reg;
  logic [1:0]    idx_next;
  logic          scan_active_reg;  // stays low until the first slot boundary
  logic          frame_latch;
  logic [3:0]    digit_in [4];
  logic [3:0]    snapshot [4];
  logic [3:0]    cur_digit;
  logic [6:0]    seg_next;

  assign tick        = (prescaler_reg == PRESCALE_LAST);
  assign idx_next    = idx_reg + 2'd1;
  assign frame_latch = tick && (idx_next == 2'd0);

  assign digit_in[0] = digit0;
  assign digit_in[1] = digit1;
  assign digit_in[2] = digit2;
  assign digit_in[3] = digit3;

  assign cur_digit = snapshot[idx_reg];

  // Slot-length prescaler; the terminal count marks a slot boundary.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      prescaler_reg <= '0;
    end else if (tick) begin
      prescaler_reg <= '0;
    end else begin
      prescaler_reg <= prescaler_reg + 1'b1;
    end
  end

  // Scan index advances on every slot boundary; display is armed at the first one.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      idx_reg         <= 2'd3;
      scan_active_reg <= 1'b0;
    end else if (tick) begin
      idx_reg         <= idx_next;
      scan_active_reg <= 1'b1;
    end
  end

  // Per-digit frame snapshot, captured only when the scan wraps to index 0.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_snapshot
      logic [3:0] digit_reg;

      // Capture this digit at the start of each frame.
      always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
          digit_reg <= 4'd0;
        end else if (frame_latch) begin
          digit_reg <= digit_in[gi];
        end
      end

      assign snapshot[gi] = digit_reg;
    end
  endgenerate

  // BCD to active-low segments, with dash for non-BCD and optional leading blank.
  always_comb begin
    seg_next = 7'h3F;
    case (cur_digit)
      4'd0: seg_next = 7'h40;
      4'd1: seg_next = 7'h79;
      4'd2: seg_next = 7'h24;
      4'd3: seg_next = 7'h30;
      4'd4: seg_next = 7'h19;
      4'd5: seg_next = 7'h12;
      4'd6: seg_next = 7'h02;
      4'd7: seg_next = 7'h78;
      4'd8: seg_next = 7'h00;
      4'd9: seg_next = 7'h10;
      default: seg_next = 7'h3F;
    endcase
    if (BLANK_LEADING && (idx_reg == 2'd3) && (cur_digit == 4'd0)) begin
      seg_next = 7'h7F;
    end
  end

  // Registered display outputs: dark on boundaries and before arming, else the current digit.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      an          <= 4'b1111;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_latch;
      if (tick || !scan_active_reg) begin
        an  <= 4'b1111;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx_reg);
        seg <= seg_next;
        dp  <= (idx_reg == DP_IDX) ? 1'b0 : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: a frame-arithmetic model checked every cycle
// against two instances (leading blank on and off), plus directed literal checks.
module tb_sevenseg_scan_driver;

  localparam int R   = 4;
  localparam int DPP = 2;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [6:0] seg_b, seg_n;
  logic       dp_b, dp_n;
  logic [3:0] an_b, an_n;
  logic       fs_b, fs_n;

  int checks = 0;
  int passes = 0;
  int e = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  sevenseg_scan_driver #(.REFRESH_DIV(R), .DP_POS(DPP), .BLANK_LEADING(1'b1)) dut_blank (
    .clk_100MHz(clk_100MHz), .reset(reset),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .seg(seg_b), .dp(dp_b), .an(an_b), .frame_start(fs_b)
  );

  sevenseg_scan_driver #(.REFRESH_DIV(R), .DP_POS(DPP), .BLANK_LEADING(1'b0)) dut_noblank (
    .clk_100MHz(clk_100MHz), .reset(reset),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .seg(seg_n), .dp(dp_n), .an(an_n), .frame_start(fs_n)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 4'd9) return 7'h3F;
    return tbl[d];
  endfunction

  // Model: edges since reset release, and digits captured at each frame boundary.
  int         n;
  logic [3:0] msnap [4];

  always @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      n <= 0;
      for (int i = 0; i < 4; i++) msnap[i] <= 4'd0;
    end else begin
      n <= n + 1;
      if ((n + 1 >= R) && (((n + 1 - R) % (4 * R)) == 0)) begin
        msnap[0] <= digit0;
        msnap[1] <= digit1;
        msnap[2] <= digit2;
        msnap[3] <= digit3;
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk_100MHz) begin
    logic [3:0] ean;
    logic [6:0] esb, esn;
    logic       edp, efs;
    int         m, idx;
    ean = 4'b1111; esb = 7'h7F; esn = 7'h7F; edp = 1'b1; efs = 1'b0;
    if (reset) begin
      if (n <= R) begin
        efs = (n == R);
      end else begin
        m = n - R;
        if ((m % R) == 0) begin
          efs = ((m % (4 * R)) == 0);
        end else begin
          idx = ((m - 1) / R) % 4;
          ean = ~(4'b0001 << idx);
          esn = dec(msnap[idx]);
          esb = (idx == 3 && msnap[idx] == 4'd0) ? 7'h7F : esn;
          edp = (idx == DPP) ? 1'b0 : 1'b1;
        end
      end
    end
    chk("model_an_b", an_b, ean);
    chk("model_seg_b", seg_b, esb);
    chk("model_dp_b", dp_b, edp);
    chk("model_fs_b", fs_b, efs);
    chk("model_an_n", an_n, ean);
    chk("model_seg_n", seg_n, esn);
    chk("model_dp_n", dp_n, edp);
    chk("model_fs_n", fs_n, efs);
  end

  task automatic tick_to(input int target);
    while (e < target) begin
      @(posedge clk_100MHz);
      e++;
    end
    #2;
  endtask

  task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
    $display("edge %0d: digits set to %0h %0h %0h %0h", e, d3, d2, d1, d0);
  endtask

  initial begin
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    reset = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    #2;
    chk("rst_an", an_b, 4'b1111);
    chk("rst_seg", seg_b, 7'h7F);
    chk("rst_dp", dp_b, 1);
    chk("rst_fs", fs_b, 0);
    reset = 1'b1;
    e = 0;
    $display("reset released");

    tick_to(3);  chk("e3_an_dark", an_b, 4'b1111);
    tick_to(4);  chk("e4_an_dark", an_b, 4'b1111); chk("e4_fs", fs_b, 1);
    tick_to(5);  chk("e5_fs_low", fs_b, 0); chk("e5_an", an_b, 4'b1110); chk("e5_seg", seg_b, 7'h19);
    tick_to(7);  chk("e7_an", an_b, 4'b1110);
    tick_to(8);  chk("e8_guard", an_b, 4'b1111);
    tick_to(9);  chk("e9_an", an_b, 4'b1101); chk("e9_seg", seg_b, 7'h30);
    tick_to(13); chk("e13_an", an_b, 4'b1011); chk("e13_seg", seg_b, 7'h24); chk("e13_dp", dp_b, 0);
    tick_to(17); chk("e17_an", an_b, 4'b0111); chk("e17_seg", seg_b, 7'h79); chk("e17_dp", dp_b, 1);
    tick_to(20); chk("e20_fs", fs_b, 1);
    tick_to(21); chk("e21_an", an_b, 4'b1110); chk("e21_seg", seg_b, 7'h19);
    $display("scan order scenario done");

    set_digits(4'd0, 4'd5, 4'd6, 4'd7);
    tick_to(37); chk("blank_d0_seg", seg_b, 7'h78);
    tick_to(45); chk("blank_d2_seg", seg_b, 7'h12); chk("blank_d2_dp", dp_b, 0);
    tick_to(49); chk("blank_an", an_b, 4'b0111); chk("blank_seg", seg_b, 7'h7F);
                 chk("noblank_seg", seg_n, 7'h40);
    $display("leading blank scenario done");

    set_digits(4'd1, 4'd2, 4'hA, 4'd4);
    tick_to(53); chk("bad_d0_seg", seg_b, 7'h19);
    tick_to(57); chk("bad_an", an_b, 4'b1101); chk("bad_seg", seg_b, 7'h3F);
    tick_to(61); chk("bad_d2_seg", seg_b, 7'h24);
    $display("invalid BCD scenario done");

    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    tick_to(73); chk("coh_d1_seg", seg_b, 7'h30);
    set_digits(4'd9, 4'd8, 4'd7, 4'd6);
    tick_to(77); chk("coh_d2_seg", seg_b, 7'h24);
    tick_to(81); chk("coh_d3_seg", seg_b, 7'h79);
    tick_to(84); chk("coh_fs", fs_b, 1);
    tick_to(85); chk("coh_new_an", an_b, 4'b1110); chk("coh_new_seg", seg_b, 7'h02);
    $display("snapshot coherence scenario done");

    tick_to(93); chk("pre_rst_an", an_b, 4'b1011);
    reset = 1'b0;
    #1;
    chk("mid_rst_an", an_b, 4'b1111);
    chk("mid_rst_seg", seg_b, 7'h7F);
    chk("mid_rst_dp", dp_b, 1);
    chk("mid_rst_fs", fs_b, 0);
    repeat (2) @(posedge clk_100MHz);
    #2;
    reset = 1'b1;
    e = 0;
    $display("reset re-released mid-operation");
    tick_to(3);  chk("r_e3_an", an_b, 4'b1111);
    tick_to(4);  chk("r_e4_fs", fs_b, 1); chk("r_e4_an", an_b, 4'b1111);
    tick_to(5);  chk("r_e5_an", an_b, 4'b1110); chk("r_e5_seg", seg_b, 7'h02);
    tick_to(9);  chk("r_e9_seg", seg_b, 7'h78);
    tick_to(20); chk("r_e20_fs", fs_b, 1);
    tick_to(22);
    $display("reset mid-operation scenario done");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
